// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one 4-bit ALU between two valid/ready requesters.
// Each requester gets its own registered response channel.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   reqN_valid_i           requester N has an operation pending
//   reqN_ready_o           operation accepted this cycle (combinational grant)
//   reqN_op_i              00 asr, 01 lsr, 10 sub, 11 add
//   reqN_a_i, reqN_b_i     operands (b used by sub/add only)
//   reqN_c_i               shift amount (used by asr/lsr only)
//   respN_valid_o          result pending for requester N
//   respN_ready_i          requester N consumes the result
//   respN_data_o           result for requester N
//   last_grant_o           index of the most recently granted requester
module alu_share_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid_i,
  output logic       req0_ready_o,
  input  logic [1:0] req0_op_i,
  input  logic [3:0] req0_a_i,
  input  logic [3:0] req0_b_i,
  input  logic [1:0] req0_c_i,
  output logic       resp0_valid_o,
  input  logic       resp0_ready_i,
  output logic [3:0] resp0_data_o,
  input  logic       req1_valid_i,
  output logic       req1_ready_o,
  input  logic [1:0] req1_op_i,
  input  logic [3:0] req1_a_i,
  input  logic [3:0] req1_b_i,
  input  logic [1:0] req1_c_i,
  output logic       resp1_valid_o,
  input  logic       resp1_ready_i,
  output logic [3:0] resp1_data_o,
  output logic       last_grant_o
);

  localparam int unsigned DW  = 4;
  localparam int unsigned OPW = 2;
  localparam int unsigned CW  = 2;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [CW-1:0]  c;
  } alu_req_t;

  logic          elig0, elig1;
  logic          gnt0, gnt1;
  alu_req_t      sel;
  logic [DW-1:0] alu_res;

  logic          resp0_valid_q, resp0_valid_d;
  logic          resp1_valid_q, resp1_valid_d;
  logic [DW-1:0] resp0_data_q, resp0_data_d;
  logic [DW-1:0] resp1_data_q, resp1_data_d;
  // ptr_q = 1 means requester 1 wins the next tie
  logic          ptr_q, ptr_d;
  logic          last_grant_q, last_grant_d;

  // Eligibility and grant; a pending result blocks a requester unless consumed now
  always_comb begin
    elig0 = req0_valid_i & (~resp0_valid_q | resp0_ready_i);
    elig1 = req1_valid_i & (~resp1_valid_q | resp1_ready_i);
    gnt0  = rst_n & elig0 & (~elig1 | FIXED_PRIO | ~ptr_q);
    gnt1  = rst_n & elig1 & ~gnt0;
  end

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;

  // Grant mux into the shared ALU
  always_comb begin
    sel = gnt1 ? alu_req_t'{req1_op_i, req1_a_i, req1_b_i, req1_c_i}
               : alu_req_t'{req0_op_i, req0_a_i, req0_b_i, req0_c_i};
  end

  // Shared ALU
  always_comb begin
    alu_res = '0;
    case (sel.op)
      2'b00:   alu_res = DW'($signed(sel.a) >>> sel.c);
      2'b01:   alu_res = sel.a >> sel.c;
      2'b10:   alu_res = sel.a - sel.b;
      default: alu_res = sel.a + sel.b;
    endcase
  end

  // Next-state for response registers, pointer and last grant
  always_comb begin
    resp0_valid_d = resp0_valid_q;
    resp1_valid_d = resp1_valid_q;
    resp0_data_d  = resp0_data_q;
    resp1_data_d  = resp1_data_q;
    ptr_d         = ptr_q;
    last_grant_d  = last_grant_q;

    if (gnt0) begin
      resp0_valid_d = 1'b1;
      resp0_data_d  = alu_res;
    end else if (resp0_ready_i) begin
      resp0_valid_d = 1'b0;
    end

    if (gnt1) begin
      resp1_valid_d = 1'b1;
      resp1_data_d  = alu_res;
    end else if (resp1_ready_i) begin
      resp1_valid_d = 1'b0;
    end

    if (gnt0 | gnt1) begin
      ptr_d        = gnt0;
      last_grant_d = gnt1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp1_data_q  <= '0;
      ptr_q         <= 1'b0;
      last_grant_q  <= 1'b0;
    end else begin
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_data_q  <= resp0_data_d;
      resp1_data_q  <= resp1_data_d;
      ptr_q         <= ptr_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign resp0_valid_o = resp0_valid_q;
  assign resp1_valid_o = resp1_valid_q;
  assign resp0_data_o  = resp0_data_q;
  assign resp1_data_o  = resp1_data_q;
  assign last_grant_o  = last_grant_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a round-robin instance and a fixed-priority
// instance share the same stimulus; a transaction-level model predicts both.
module tb_alu_share_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] resp_ready;
  logic [1:0] req_op [2];
  logic [3:0] req_a  [2];
  logic [3:0] req_b  [2];
  logic [1:0] req_c  [2];

  logic [1:0] d_rdy [2];
  logic [1:0] d_rv  [2];
  logic [3:0] d_rd0 [2];
  logic [3:0] d_rd1 [2];
  logic       d_lg  [2];

  logic r0_rr, r1_rr, v0_rr, v1_rr, lg_rr;
  logic r0_fp, r1_fp, v0_fp, v1_fp, lg_fp;
  logic [3:0] dd0_rr, dd1_rr, dd0_fp, dd1_fp;

  int checks = 0;
  int errors = 0;

  // Model state per instance k (0 = round-robin, 1 = fixed priority)
  bit m_init = 0;
  bit m_rv [2][2];
  int m_rd [2][2];
  int m_fav [2];
  int m_lg [2];

  alu_share_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req_valid[0]), .req0_ready_o(r0_rr), .req0_op_i(req_op[0]),
    .req0_a_i(req_a[0]), .req0_b_i(req_b[0]), .req0_c_i(req_c[0]),
    .resp0_valid_o(v0_rr), .resp0_ready_i(resp_ready[0]), .resp0_data_o(dd0_rr),
    .req1_valid_i(req_valid[1]), .req1_ready_o(r1_rr), .req1_op_i(req_op[1]),
    .req1_a_i(req_a[1]), .req1_b_i(req_b[1]), .req1_c_i(req_c[1]),
    .resp1_valid_o(v1_rr), .resp1_ready_i(resp_ready[1]), .resp1_data_o(dd1_rr),
    .last_grant_o(lg_rr)
  );

  alu_share_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req_valid[0]), .req0_ready_o(r0_fp), .req0_op_i(req_op[0]),
    .req0_a_i(req_a[0]), .req0_b_i(req_b[0]), .req0_c_i(req_c[0]),
    .resp0_valid_o(v0_fp), .resp0_ready_i(resp_ready[0]), .resp0_data_o(dd0_fp),
    .req1_valid_i(req_valid[1]), .req1_ready_o(r1_fp), .req1_op_i(req_op[1]),
    .req1_a_i(req_a[1]), .req1_b_i(req_b[1]), .req1_c_i(req_c[1]),
    .resp1_valid_o(v1_fp), .resp1_ready_i(resp_ready[1]), .resp1_data_o(dd1_fp),
    .last_grant_o(lg_fp)
  );

  assign d_rdy[0] = {r1_rr, r0_rr};
  assign d_rdy[1] = {r1_fp, r0_fp};
  assign d_rv[0]  = {v1_rr, v0_rr};
  assign d_rv[1]  = {v1_fp, v0_fp};
  assign d_rd0[0] = dd0_rr;
  assign d_rd0[1] = dd0_fp;
  assign d_rd1[0] = dd1_rr;
  assign d_rd1[1] = dd1_fp;
  assign d_lg[0]  = lg_rr;
  assign d_lg[1]  = lg_fp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int alu_ref(int op, int a, int b, int c);
    int sa;
    case (op)
      0: begin
        sa = (a >= 8) ? a - 16 : a;
        return (sa >>> c) & 15;
      end
      1: return a / (1 << c);
      2: return (a - b + 16) % 16;
      default: return (a + b) % 16;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare both instances against the model, then advance the model by one edge
  task automatic model_cycle();
    int  g;
    bit  e0, e1;
    int  dat;
    for (int k = 0; k < 2; k++) begin
      g = -1;
      if (rst_n && m_init) begin
        e0 = req_valid[0] && (!m_rv[k][0] || resp_ready[0]);
        e1 = req_valid[1] && (!m_rv[k][1] || resp_ready[1]);
        if (e0 && e1) g = (k == 1) ? 0 : m_fav[k];
        else if (e0)  g = 0;
        else if (e1)  g = 1;
      end
      if (!rst_n || m_init) begin
        chk($sformatf("m%0d_req0_ready", k), int'(d_rdy[k][0]), int'(g == 0));
        chk($sformatf("m%0d_req1_ready", k), int'(d_rdy[k][1]), int'(g == 1));
      end
      if (m_init) begin
        chk($sformatf("m%0d_resp0_valid", k), int'(d_rv[k][0]), int'(m_rv[k][0]));
        chk($sformatf("m%0d_resp1_valid", k), int'(d_rv[k][1]), int'(m_rv[k][1]));
        chk($sformatf("m%0d_resp0_data", k), int'(d_rd0[k]), m_rd[k][0]);
        chk($sformatf("m%0d_resp1_data", k), int'(d_rd1[k]), m_rd[k][1]);
        chk($sformatf("m%0d_last_grant", k), int'(d_lg[k]), m_lg[k]);
      end
      if (!rst_n) begin
        m_rv[k][0] = 0; m_rv[k][1] = 0;
        m_rd[k][0] = 0; m_rd[k][1] = 0;
        m_fav[k] = 0; m_lg[k] = 0;
      end else if (m_init) begin
        for (int n = 0; n < 2; n++) begin
          if (g == n) begin
            dat = alu_ref(int'(req_op[n]), int'(req_a[n]), int'(req_b[n]), int'(req_c[n]));
            m_rv[k][n] = 1;
            m_rd[k][n] = dat;
          end else if (resp_ready[n]) begin
            m_rv[k][n] = 0;
          end
        end
        if (g >= 0) begin
          m_fav[k] = 1 - g;
          m_lg[k]  = g;
        end
      end
    end
    if (!rst_n) m_init = 1;
  endtask

  // One clock: model compare at the falling edge, return 1 after the rising edge
  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input bit v, input int op, input int a,
                       input int b, input int c);
    req_valid[n] = v;
    req_op[n]    = 2'(op);
    req_a[n]     = 4'(a);
    req_b[n]     = 4'(b);
    req_c[n]     = 2'(c);
  endtask

  int vop [4] = '{0, 1, 2, 0};
  int va  [4] = '{8, 8, 3, 6};
  int vb  [4] = '{0, 0, 5, 0};
  int vc  [4] = '{2, 2, 0, 3};
  int vex [4] = '{14, 2, 14, 0};

  initial begin
    rst_n      = 1'b0;
    resp_ready = 2'b11;
    drive(0, 1, 3, 7, 9, 0);
    drive(1, 1, 3, 1, 1, 0);

    // Reset held two cycles with both requesting
    #2;
    chk("rst_req0_ready", int'(r0_rr), 0);
    chk("rst_req1_ready", int'(r1_rr), 0);
    tick();
    tick();
    chk("rst_resp0_valid", int'(v0_rr), 0);
    chk("rst_resp1_valid", int'(v1_rr), 0);
    chk("rst_resp0_data", int'(dd0_rr), 0);
    chk("rst_resp1_data", int'(dd1_rr), 0);
    chk("rst_last_grant", int'(lg_rr), 0);

    // First grant after release goes to requester 0: 7 + 9 wraps to 0
    rst_n = 1'b1;
    #1;
    chk("first_grant_req0", int'(r0_rr), 1);
    chk("first_grant_req1", int'(r1_rr), 0);
    tick();
    chk("add_wrap_valid", int'(v0_rr), 1);
    chk("add_wrap_data", int'(dd0_rr), 0);

    // Op coverage on requester 1, back-to-back
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, vop[i], va[i], vb[i], vc[i]);
      #1;
      chk($sformatf("op%0d_ready", i), int'(r1_rr), 1);
      tick();
      chk($sformatf("op%0d_valid", i), int'(v1_rr), 1);
      chk($sformatf("op%0d_data", i), int'(dd1_rr), vex[i]);
    end

    // Contention: round-robin alternates, fixed priority always picks 0
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 3, i, 1, 0);
      drive(1, 1, 2, i, 1, 0);
      #1;
      chk($sformatf("rr_req0_ready_%0d", i), int'(r0_rr), int'(i % 2 == 0));
      chk($sformatf("rr_req1_ready_%0d", i), int'(r1_rr), int'(i % 2 == 1));
      chk($sformatf("fp_req0_ready_%0d", i), int'(r0_fp), 1);
      chk($sformatf("fp_req1_ready_%0d", i), int'(r1_fp), 0);
      tick();
      chk($sformatf("rr_last_grant_%0d", i), int'(lg_rr), i % 2);
      if (i % 2 == 0) begin
        chk($sformatf("rr_resp0_data_%0d", i), int'(dd0_rr), (i + 1) % 16);
        chk($sformatf("rr_resp1_valid_%0d", i), int'(v1_rr), 0);
      end else begin
        chk($sformatf("rr_resp1_data_%0d", i), int'(dd1_rr), (i + 15) % 16);
        chk($sformatf("rr_resp0_valid_%0d", i), int'(v0_rr), 0);
      end
    end
    drive(0, 0, 3, 0, 0, 0);
    #1;
    chk("fp_req1_after_drop", int'(r1_fp), 1);
    tick();

    // Backpressure on requester 0
    resp_ready = 2'b10;
    drive(0, 1, 3, 2, 3, 0);
    drive(1, 1, 3, 4, 4, 0);
    #1;
    chk("bp_first_grant", int'(r0_rr), 1);
    tick();
    chk("bp_first_valid", int'(v0_rr), 1);
    chk("bp_first_data", int'(dd0_rr), 5);
    for (int j = 0; j < 3; j++) begin
      drive(0, 1, 3, j + 10, j, 0);
      drive(1, 1, 3, j, 1, 0);
      #1;
      chk($sformatf("bp_req0_ready_%0d", j), int'(r0_rr), 0);
      chk($sformatf("bp_req1_ready_%0d", j), int'(r1_rr), 1);
      tick();
      chk($sformatf("bp_hold_valid_%0d", j), int'(v0_rr), 1);
      chk($sformatf("bp_hold_data_%0d", j), int'(dd0_rr), 5);
      chk($sformatf("bp_req1_data_%0d", j), int'(dd1_rr), j + 1);
    end
    resp_ready = 2'b11;
    drive(0, 1, 2, 1, 2, 0);
    #1;
    chk("bp_release_grant", int'(r0_rr), 1);
    tick();
    chk("bp_release_valid", int'(v0_rr), 1);
    chk("bp_release_data", int'(dd0_rr), 15);

    // Random traffic with occasional mid-operation resets
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 39) != 0);
      resp_ready = 2'($urandom_range(0, 3));
      for (int n = 0; n < 2; n++)
        drive(n, ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter that shares one instance of the team's 4-bit ALU between two independent requesters. Each requester issues a valid/ready operation request and gets a registered result on its own valid/ready response channel. The block sits between the two client state machines and the single ALU. It guarantees at most one ALU operation per cycle and one-cycle issue-to-result latency.

## Interface
- FIXED_PRIO, default 0: 0 selects round-robin between requesters; 1 makes requester 0 always win when both are eligible.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0's operation is accepted this cycle.
- req0_op  in  2  ALU op: 00 arithmetic shift right, 01 logical shift right, 10 subtract, 11 add.
- req0_a  in  4  operand A.
- req0_b  in  4  operand B (used by ops 10 and 11 only).
- req0_c  in  2  shift amount (used by ops 00 and 01 only).
- resp0_valid  out  1  result available for requester 0.
- resp0_ready  in  1  requester 0 consumes the result.
- resp0_data  out  4  result for requester 0.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_c  same as the requester 0 signals, for requester 1.
- resp1_valid, resp1_ready, resp1_data  same as the requester 0 signals, for requester 1.
- last_grant  out  1  index of the most recently granted requester.

## Operation
- **ALU semantics.** All results are 4-bit and wrap mod 16.
  - op 00: A arithmetic-shifted right by C, sign-filled from A[3].
  - op 01: A logically shifted right by C, zero-filled.
  - op 10: A − B.
  - op 11: A + B.
- **Eligibility.** eligN = reqN_valid & (~respN_valid | respN_ready). A requester whose result is still unconsumed cannot be granted, unless it consumes in the same cycle.
- **Grant selection.**
  - Only one eligible requester: it is granted.
  - Both eligible: the round-robin pointer picks the winner, or requester 0 when FIXED_PRIO=1.
  - Neither eligible: no grant, and ALU inputs are don't-care.
- **reqN_ready.** Combinational; equals grantN. It is 1 only in the cycle of acceptance and forced 0 while rst_n=0.
- **Grant mux.** The granted requester's op, a, b and c drive the single ALU instance. The ALU output is captured at the clock edge.
- **Response register, on a grant to N:** respN_data <= ALU result and respN_valid <= 1.
- **Response register, no grant to N:** if respN_ready then respN_valid <= 0. respN_data holds its value until the next grant to N.
- **Round-robin pointer.** After any grant, the pointer points to the other requester. The pointer does not change when there is no grant. last_grant <= index of the granted requester.
- **Input stability.** Requests are not required to be stable before acceptance. Only the values present in the accept cycle are used.

## Timing
- **Reset** (rst_n=0 at a rising edge):
  - resp0_valid=resp1_valid=0
  - resp0_data=resp1_data=4'h0
  - last_grant=0
  - pointer favours requester 0.
- **Reset mid-operation.** Pending responses are discarded and no grant occurs in a reset cycle.
- **Latency.** Accept in cycle T, then respN_valid=1 with data in cycle T+1.
- **Throughput.**
  - One operation per cycle in total across both requesters.
  - One per cycle per requester when its respN_ready is held at 1 (back-to-back).
- **Simultaneous consume and new grant to N.** respN_valid stays 1 and data updates to the new result. No bubble is inserted and the old result is not lost (it was consumed).
- **Response stability.** Under backpressure (respN_valid=1, respN_ready=0), respN_data and respN_valid are stable and reqN_ready=0. The other requester is unaffected.
- **Stalled requester.** A blocked requester does not consume a round-robin turn; the pointer advances only on actual grants.

## Test plan
- **Reset.** Hold rst_n=0 for 2 cycles with req0_valid=req1_valid=1 → req*_ready=0 and resp*_valid=0, resp*_data=0, last_grant=0. After release, the first grant goes to requester 0.
- **Single add with wrap.** req0 op=11, a=7, b=9 → req0_ready=1 the same cycle. Next cycle resp0_valid=1, resp0_data=4'h0.
- **Op coverage on req1.**
  - op=00, a=4'b1000, c=2 → 4'b1110.
  - op=01, a=4'b1000, c=2 → 4'b0010.
  - op=10, a=3, b=5 → 4'b1110.
  - op=00, a=4'b0110, c=3 → 4'b0000.
- **Contention.** Both valid every cycle, both resp_ready=1 → grants alternate 0,1,0,1. last_grant toggles. Each resp_valid is asserted every other cycle with the correct data.
- **Backpressure.** resp0_ready=0 after the first result → req0_ready stays 0 and resp0_data holds. req1 is granted every cycle. Raising resp0_ready gives requester 0 its grant in the same cycle, and the new result appears the next cycle with resp0_valid continuously 1.
- **Fixed priority.** FIXED_PRIO=1 with both valid and resp_ready=1 → requester 0 granted every cycle and requester 1 never granted until req0_valid drops.
